// File: rtl/prog_loader_if.sv
// Byte-stream, ROM write port and status signals shared by the program loader
// and whatever drives it (UART bridge, debug port, testbench).
interface prog_loader_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, rom_we, rom_waddr, rom_wdata,
    input  cpu_hold, busy, done, err, err_code
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, rom_we, rom_waddr, rom_wdata,
    output cpu_hold, busy, done, err, err_code
  );
endinterface

// File: rtl/prog_loader.sv
// Program downloader: unpacks a framed byte stream into little-endian 32-bit
// ROM words and keeps the CPU in reset until a checksummed image is in place.
module prog_loader #(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam int          CNT_W     = $clog2(TIMEOUT_CYC);
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              rx_ready_q, cpu_hold_q, done_q, err_q;
  logic              rom_we_q;
  logic [ADDR_W-1:0] rom_waddr_q, idx_q, last_q;
  logic [31:0]       rom_wdata_q;
  logic [23:0]       word_q;
  logic [1:0]        byte_cnt_q;
  logic [7:0]        acc_q, len_lo_q;
  logic [CNT_W-1:0]  idle_q;

  logic        accept, in_frame, timeout, len_bad;
  logic [15:0] len_word;

  assign accept   = bus.rx_valid & rx_ready_q;
  assign len_word = {bus.rx_data, len_lo_q};
  assign len_bad  = (len_word == 16'd0) || ({1'b0, len_word} > MAX_WORDS);
  assign in_frame = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  // An accept in the expiry cycle wins, so only a byte-less cycle can time out.
  assign timeout  = in_frame && !accept && (idle_q == CNT_W'(TIMEOUT_CYC - 1));

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_d = S_SYNC;
      S_SYNC: if (accept && bus.rx_data == 8'hA5) state_d = S_LEN0;
      S_LEN0: if (accept) state_d = S_LEN1;
      S_LEN1:
        if (accept) begin
          if (len_bad) begin
            state_d    = S_ERR;
            err_code_d = 2'd1;
          end else begin
            state_d = S_DATA;
          end
        end
      S_DATA: if (accept && byte_cnt_q == 2'd3 && idx_q == last_q) state_d = S_CSUM;
      S_CSUM:
        if (accept) begin
          if (bus.rx_data == acc_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = 2'd2;
          end
        end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d    = S_ERR;
      err_code_d = 2'd3;
    end
    if (state_d == S_SYNC) err_code_d = 2'd0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      err_code_q  <= 2'd0;
      rx_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      word_q      <= '0;
      byte_cnt_q  <= 2'd0;
      acc_q       <= 8'h00;
      len_lo_q    <= 8'h00;
      idle_q      <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      rx_ready_q <= state_d inside {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM};
      cpu_hold_q <= state_d inside {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_ERR};
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      rom_we_q   <= 1'b0;

      if (accept || state_d == S_SYNC) idle_q <= '0;
      else if (in_frame)               idle_q <= idle_q + 1'b1;

      if (state_d == S_SYNC && state_q != S_SYNC) begin
        idx_q      <= '0;
        acc_q      <= 8'h00;
        byte_cnt_q <= 2'd0;
      end else if (accept) begin
        unique case (state_q)
          S_LEN0: len_lo_q <= bus.rx_data;
          S_LEN1: last_q   <= ADDR_W'(len_word - 16'd1);
          S_DATA: begin
            acc_q      <= acc_q ^ bus.rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
              2'd0: word_q[7:0]   <= bus.rx_data;
              2'd1: word_q[15:8]  <= bus.rx_data;
              2'd2: word_q[23:16] <= bus.rx_data;
              default: begin
                rom_we_q    <= 1'b1;
                rom_waddr_q <= idx_q;
                rom_wdata_q <= {bus.rx_data, word_q};
                idx_q       <= idx_q + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.busy      = rx_ready_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_waddr = rom_waddr_q;
  assign bus.rom_wdata = rom_wdata_q;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames, random frames with
// random gaps, bad-length, bad-checksum, timeout and mid-frame reset.
module tb_prog_loader;
  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [31:0]       words_q[$];
  logic [7:0]        junk_q[$];

  always @(negedge clk) begin
    if (bus.rom_we === 1'b1) begin
      wa_q.push_back(bus.rom_waddr);
      wd_q.push_back(bus.rom_wdata);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    while (bus.rx_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ":rx_ready"},  32'(bus.rx_ready),  32'd0);
    check({tag, ":busy"},      32'(bus.busy),      32'd0);
    check({tag, ":cpu_hold"},  32'(bus.cpu_hold),  32'd0);
    check({tag, ":done"},      32'(bus.done),      32'd0);
    check({tag, ":err"},       32'(bus.err),       32'd0);
    check({tag, ":err_code"},  32'(bus.err_code),  32'd0);
    check({tag, ":rom_we"},    32'(bus.rom_we),    32'd0);
    check({tag, ":rom_waddr"}, 32'(bus.rom_waddr), 32'd0);
    check({tag, ":rom_wdata"}, bus.rom_wdata,      32'd0);
  endtask

  // Reference model: a frame either loads all N words at 0..N-1 (good length),
  // or nothing (bad length); outcome decided by length rule and checksum.
  task automatic run_frame(input string name, input logic [15:0] n, input bit rand_words,
                           input logic [7:0] csum_flip, input int max_gap, input bit mid_start);
    logic [7:0]  stream[$];
    logic [7:0]  csum;
    logic [31:0] w;
    bit          len_ok;
    bit          exp_done;
    int          nwr;
    len_ok = (n != 16'd0) && (int'(n) <= (1 << ADDR_W));
    if (rand_words) begin
      words_q.delete();
      if (len_ok) for (int i = 0; i < int'(n); i++) words_q.push_back($urandom);
    end
    csum = 8'h00;
    foreach (junk_q[i]) stream.push_back(junk_q[i]);
    stream.push_back(8'hA5);
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    if (len_ok) begin
      foreach (words_q[i]) begin
        w = words_q[i];
        for (int k = 0; k < 4; k++) begin
          stream.push_back(w[8*k +: 8]);
          csum ^= w[8*k +: 8];
        end
      end
      stream.push_back(csum ^ csum_flip);
    end
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    check({name, ":busy_after_start"}, 32'(bus.busy), 32'd1);
    foreach (stream[i]) begin
      if (mid_start && i == 6) pulse_start();
      send_byte(stream[i]);
      if (max_gap > 0) tick($urandom_range(0, max_gap));
    end
    @(negedge clk);
    exp_done = len_ok && (csum_flip == 8'h00);
    check({name, ":done"},     32'(bus.done),     32'(exp_done));
    check({name, ":err"},      32'(bus.err),      32'(!exp_done));
    check({name, ":err_code"}, 32'(bus.err_code), !len_ok ? 32'd1 : (csum_flip != 8'h00 ? 32'd2 : 32'd0));
    check({name, ":cpu_hold"}, 32'(bus.cpu_hold), 32'(!exp_done));
    check({name, ":busy"},     32'(bus.busy),     32'd0);
    nwr = len_ok ? words_q.size() : 0;
    check({name, ":n_writes"}, 32'(wa_q.size()), 32'(nwr));
    for (int i = 0; i < nwr && i < wa_q.size(); i++) begin
      check({name, ":waddr"}, 32'(wa_q[i]), 32'(i));
      check({name, ":wdata"}, wd_q[i], words_q[i]);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst          = 1'b0;
    #1 rst = 1'b1;
    #2 check_quiet("reset");
    tick(2);
    rst = 1'b0;
    tick(1);
    check_quiet("idle");

    // Single-word image.
    junk_q.delete();
    words_q = '{32'h0000_0013};
    run_frame("one_word", 16'd1, 1'b0, 8'h00, 0, 1'b0);

    // Leading junk before sync, two words.
    junk_q  = '{8'h00, 8'hFF};
    words_q = '{32'h0403_0201, 32'h0807_0605};
    run_frame("junk_two", 16'd2, 1'b0, 8'h00, 0, 1'b0);

    // Checksum byte sent as 0x00 where 0x44 is correct.
    junk_q.delete();
    words_q = '{32'h4433_2211};
    run_frame("bad_csum", 16'd1, 1'b0, 8'h44, 0, 1'b0);

    // Restart from ERR clears status.
    pulse_start();
    check("restart:err",      32'(bus.err),      32'd0);
    check("restart:err_code", 32'(bus.err_code), 32'd0);
    check("restart:cpu_hold", 32'(bus.cpu_hold), 32'd1);
    tick(1);

    // Length boundaries.
    run_frame("len_zero", 16'd0,   1'b1, 8'h00, 0, 1'b0);
    run_frame("len_17",   16'd17,  1'b1, 8'h00, 0, 1'b0);
    run_frame("len_256",  16'h100, 1'b1, 8'h00, 0, 1'b0);
    run_frame("len_max",  16'd16,  1'b1, 8'h00, 3, 1'b0);

    // Random frames with random junk, gaps, corruption and an ignored start.
    for (int r = 0; r < 8; r++) begin
      junk_q.delete();
      repeat ($urandom_range(0, 3)) begin
        junk_q.push_back(8'($urandom_range(0, 255)));
        if (junk_q[$] == 8'hA5) junk_q[$] = 8'h5A;
      end
      run_frame("random", 16'($urandom_range(1, 16)), 1'b1,
                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                $urandom_range(0, 10), r == 2);
    end

    // Timeout after the first data byte.
    junk_q.delete();
    wa_q.delete();
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    tick(TIMEOUT_CYC - 1);
    check("timeout:not_yet",  32'(bus.err),      32'd0);
    check("timeout:ready",    32'(bus.rx_ready), 32'd1);
    tick(1);
    check("timeout:err",      32'(bus.err),      32'd1);
    check("timeout:err_code", 32'(bus.err_code), 32'd3);
    check("timeout:rx_ready", 32'(bus.rx_ready), 32'd0);
    check("timeout:cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("timeout:n_writes", 32'(wa_q.size()),  32'd0);

    // Asynchronous reset in the middle of DATA, then a clean reload.
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
    #2 rst = 1'b1;
    #1 check_quiet("mid_rst");
    tick(2);
    rst = 1'b0;
    tick(1);
    run_frame("after_rst", 16'd3, 1'b1, 8'h00, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
